// File: rtl/pim_pkg.sv
// Shared definitions for the PIM MAC datapath: the controller state type,
// default sizes, and the IMPL_TYPE codes understood by multiplier_nbit and adder_nbit.
package pim_pkg;

   typedef enum logic {
      S_RUN  = 1'b0,
      S_HOLD = 1'b1
   } state_t;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_CNT_W = 8;

   // IMPL_TYPE codes: behavioural operators or an explicit bit-level structure
   localparam int IMPL_BEHAV = 0;
   localparam int IMPL_ARRAY = 1;

endpackage

// File: rtl/adder_nbit.sv
// Combinational WIDTH-bit adder with carry in/out.
// IMPL_TYPE selects a behavioural '+' or an explicit ripple-carry chain.
module adder_nbit
   import pim_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int IMPL_TYPE = IMPL_BEHAV
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o
);

   generate
      if (IMPL_TYPE == IMPL_BEHAV) begin : g_behav
         assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
      end else begin : g_ripple
         logic [WIDTH:0] c;
         assign c[0] = cin_i;
         for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign sum_o[gi] = a_i[gi] ^ b_i[gi] ^ c[gi];
            assign c[gi+1]   = (a_i[gi] & b_i[gi]) | (c[gi] & (a_i[gi] ^ b_i[gi]));
         end
         assign cout_o = c[WIDTH];
      end
   endgenerate

endmodule

// File: rtl/multiplier_nbit.sv
// Combinational WIDTH x WIDTH multiplier returning the lower WIDTH product bits.
// IMPL_TYPE selects a behavioural '*' or an explicit shift-and-add array.
module multiplier_nbit
   import pim_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int IMPL_TYPE = IMPL_BEHAV
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] p_o
);

   generate
      if (IMPL_TYPE == IMPL_BEHAV) begin : g_behav
         assign p_o = a_i * b_i;
      end else begin : g_array
         // Running partial sums; row gi adds a_i shifted by gi when b_i[gi] is set
         logic [WIDTH-1:0] pp [WIDTH+1];
         assign pp[0] = '0;
         for (genvar gi = 0; gi < WIDTH; gi++) begin : g_row
            assign pp[gi+1] = pp[gi] + (b_i[gi] ? (a_i << gi) : '0);
         end
         assign p_o = pp[WIDTH];
      end
   endgenerate

endmodule

// File: rtl/pim_operand_reg.sv
// Stage-1 operand register: captures an operand pair and its last flag on
// load, and raises valid for exactly the cycle following each load.
module pim_operand_reg
   import pim_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             last_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o,
   output logic             last_o
);

   logic             valid_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             last_q;

   // Data loads only on acceptance; valid follows the load enable every cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= load_i;
         if (load_i) begin
            a_q    <= a_i;
            b_q    <= b_i;
            last_q <= last_i;
         end
      end
   end

   assign valid_o = valid_q;
   assign a_o     = a_q;
   assign b_o     = b_q;
   assign last_o  = last_q;

endmodule

// File: rtl/pim_mac_accumulator.sv
// Streaming multiply-accumulate: registers each accepted operand pair, multiplies
// it, adds the truncated product into a running sum and presents sum and beat
// count on a valid/ready port after the last beat.
// Optional build macro PIM_MAC_SATURATE_EN: saturating accumulation plus sat_flag output.
module pim_mac_accumulator
   import pim_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int IMPL_TYPE = IMPL_BEHAV,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic [CNT_W-1:0] out_count
`ifdef PIM_MAC_SATURATE_EN
   ,
   output logic             sat_flag
`endif
);

   logic             accept;
   logic             s1_valid;
   logic             s1_last;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [WIDTH-1:0] product;
   logic [WIDTH-1:0] add_sum;
   logic             add_cout;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] count_q, count_d;
`ifdef PIM_MAC_SATURATE_EN
   logic             sat_q, sat_d;
`else
   logic             unused_cout;
   assign unused_cout = add_cout;
`endif

   // A pending last beat in stage 1 blocks intake so the result is not overrun
   assign in_ready = (state_q == S_RUN) && !(s1_valid && s1_last);
   assign accept   = in_valid && in_ready;

   pim_operand_reg #(.WIDTH(WIDTH)) u_opreg (
      .clk    (clk),
      .rst    (rst),
      .load_i (accept),
      .a_i    (in_a),
      .b_i    (in_b),
      .last_i (in_last),
      .valid_o(s1_valid),
      .a_o    (s1_a),
      .b_o    (s1_b),
      .last_o (s1_last)
   );

   multiplier_nbit #(.WIDTH(WIDTH), .IMPL_TYPE(IMPL_TYPE)) u_mult (
      .a_i(s1_a),
      .b_i(s1_b),
      .p_o(product)
   );

   adder_nbit #(.WIDTH(WIDTH), .IMPL_TYPE(IMPL_TYPE)) u_add (
      .a_i   (acc_q),
      .b_i   (product),
      .cin_i (1'b0),
      .sum_o (add_sum),
      .cout_o(add_cout)
   );

   // Next-state: clear on result handshake, otherwise accumulate stage-1 beats
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      count_d = count_q;
`ifdef PIM_MAC_SATURATE_EN
      sat_d   = sat_q;
`endif
      if (state_q == S_HOLD && out_ready) begin
         state_d = S_RUN;
         acc_d   = '0;
         count_d = '0;
`ifdef PIM_MAC_SATURATE_EN
         sat_d   = 1'b0;
`endif
      end else if (s1_valid) begin
`ifdef PIM_MAC_SATURATE_EN
         // Once clamped, stay clamped for the rest of the vector
         if (add_cout || sat_q) begin
            acc_d = '1;
            sat_d = 1'b1;
         end else begin
            acc_d = add_sum;
         end
`else
         acc_d = add_sum;
`endif
         count_d = count_q + CNT_W'(1);
         if (s1_last) begin
            state_d = S_HOLD;
         end
      end
   end

   // State, accumulator and counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_RUN;
         acc_q   <= '0;
         count_q <= '0;
`ifdef PIM_MAC_SATURATE_EN
         sat_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         count_q <= count_d;
`ifdef PIM_MAC_SATURATE_EN
         sat_q   <= sat_d;
`endif
      end
   end

   assign out_valid = (state_q == S_HOLD);
   assign out_sum   = acc_q;
   assign out_count = count_q;
`ifdef PIM_MAC_SATURATE_EN
   assign sat_flag  = sat_q;
`endif

endmodule
